mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the execute stage. Consumes the execute stage's
//  rd address/data, short inst code and effective address; performs loads/stores as byte-serial

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over a req/ack port, registered writeback.
// Non-memory results pass straight to writeback with one cycle of latency.

`ifndef InstShort
`define InstShort 3:0
`define instNOP   4'd0
`define instLB    4'd1
`define instLH    4'd2
`define instLW    4'd3
`define instLBU   4'd4
`define instLHU   4'd5
`define instSB    4'd6
`define instSH    4'd7
`define instSW    4'd8
`endif

module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [4:0]        rd_address_in,
  input  logic [31:0]       rd_data_in,
  input  logic              rd_we_in,
  input  logic [`InstShort] inst_in,
  input  logic [ADDR_W-1:0] mem_address_in,
  output logic              mem_req_out,
  output logic              mem_wr_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_wdata_out,
  input  logic [7:0]        mem_rdata_in,
  input  logic              mem_ack_in,
  output logic              stall_out,
  output logic [4:0]        wb_rd_address,
  output logic [31:0]       wb_rd_data,
  output logic              wb_we,
  output logic              ld_busy_out,
  output logic [4:0]        ld_rd_out
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  function automatic logic f_is_load(input logic [`InstShort] i);
    return (i == `instLB) || (i == `instLH) || (i == `instLW) ||
           (i == `instLBU) || (i == `instLHU);
  endfunction

  function automatic logic f_is_store(input logic [`InstShort] i);
    return (i == `instSB) || (i == `instSH) || (i == `instSW);
  endfunction

  // Index of the final byte of the access (nbytes - 1).
  function automatic logic [1:0] f_last_idx(input logic [`InstShort] i);
    logic [1:0] n;
    n = 2'd0;
    if ((i == `instLH) || (i == `instLHU) || (i == `instSH)) n = 2'd1;
    if ((i == `instLW) || (i == `instSW)) n = 2'd3;
    return n;
  endfunction

  state_e            r_state;
  state_e            w_state_next;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_data;
  logic [4:0]        r_rd;
  logic [`InstShort] r_inst;
  logic [31:0]       r_buf;
  logic [4:0]        r_wb_rd_address;
  logic [31:0]       r_wb_rd_data;
  logic              r_wb_we;

  logic              w_in_is_mem;
  logic              w_access;
  logic              w_is_load;
  logic              w_last;
  logic [4:0]        w_byte_sel;
  logic [31:0]       w_buf_merged;
  logic [31:0]       w_load_result;

  assign w_in_is_mem = f_is_load(inst_in) || f_is_store(inst_in);
  assign w_access    = (r_state == StAccess);
  assign w_is_load   = f_is_load(r_inst);
  assign w_last      = (r_cnt == f_last_idx(r_inst));
  assign w_byte_sel  = {r_cnt, 3'b000};

  // Next FSM state; only consulted when rdy_in allows state to move.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_in_is_mem) w_state_next = StAccess;
      StAccess: if (mem_ack_in && w_last) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // FSM state register; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= StIdle;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  // Load buffer with the byte arriving this cycle merged in, so the completion edge sees it.
  always_comb begin
    w_buf_merged = r_buf;
    w_buf_merged[w_byte_sel +: 8] = mem_rdata_in;
  end

  // Width/sign extension of the assembled load value.
  always_comb begin
    w_load_result = w_buf_merged;
    unique case (r_inst)
      `instLB:  w_load_result = {{24{w_buf_merged[7]}}, w_buf_merged[7:0]};
      `instLH:  w_load_result = {{16{w_buf_merged[15]}}, w_buf_merged[15:0]};
      `instLBU: w_load_result = {24'd0, w_buf_merged[7:0]};
      `instLHU: w_load_result = {16'd0, w_buf_merged[15:0]};
      default:  w_load_result = w_buf_merged;
    endcase
  end

  // Access capture, byte counting and writeback registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt           <= 2'd0;
      r_base          <= '0;
      r_data          <= 32'd0;
      r_rd            <= 5'd0;
      r_inst          <= `instNOP;
      r_buf           <= 32'd0;
      r_wb_rd_address <= 5'd0;
      r_wb_rd_data    <= 32'd0;
      r_wb_we         <= 1'b0;
    end else if (rdy_in) begin
      if (!w_access) begin
        if (w_in_is_mem) begin
          r_base  <= mem_address_in;
          r_data  <= rd_data_in;
          r_rd    <= rd_address_in;
          r_inst  <= inst_in;
          r_cnt   <= 2'd0;
          r_buf   <= 32'd0;
          r_wb_we <= 1'b0;
        end else begin
          r_wb_rd_address <= rd_address_in;
          r_wb_rd_data    <= rd_data_in;
          r_wb_we         <= rd_we_in && (rd_address_in != 5'd0);
        end
      end else if (mem_ack_in) begin
        if (w_is_load) r_buf <= w_buf_merged;
        r_cnt <= r_cnt + 2'd1;
        if (w_last) begin
          if (w_is_load) begin
            r_wb_rd_data    <= w_load_result;
            r_wb_rd_address <= r_rd;
            r_wb_we         <= (r_rd != 5'd0);
          end else begin
            r_wb_we <= 1'b0;
          end
        end
      end
    end
  end

  // Memory port and hazard outputs.
  always_comb begin
    mem_req_out   = rdy_in && w_access;
    mem_wr_out    = w_access && !w_is_load;
    mem_addr_out  = w_access ? (r_base + ADDR_W'(r_cnt)) : '0;
    mem_wdata_out = w_access ? r_data[w_byte_sel +: 8] : 8'd0;
    // Completion edge releases upstream so the mem inst is never re-issued.
    stall_out     = rst_in && rdy_in &&
                    ((!w_access && w_in_is_mem) || (w_access && !(mem_ack_in && w_last)));
    ld_busy_out   = w_access && w_is_load;
    ld_rd_out     = (w_access && w_is_load) ? r_rd : 5'd0;
  end

  assign wb_rd_address = r_wb_rd_address;
  assign wb_rd_data    = r_wb_rd_data;
  assign wb_we         = r_wb_we;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected transfers/writebacks, monitors pop.
module tb_mem_stage;

  localparam logic [3:0] I_NOP = 4'd0, I_LB = 4'd1, I_LH = 4'd2, I_LW = 4'd3, I_LBU = 4'd4,
                         I_LHU = 4'd5, I_SB = 4'd6, I_SH = 4'd7, I_SW = 4'd8, I_ADDI = 4'd9;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [4:0]  rd_address_in = '0;
  logic [31:0] rd_data_in = '0;
  logic        rd_we_in = 1'b0;
  logic [3:0]  inst_in = I_NOP;
  logic [31:0] mem_address_in = '0;
  logic        mem_req_out, mem_wr_out;
  logic [31:0] mem_addr_out;
  logic [7:0]  mem_wdata_out;
  logic [7:0]  mem_rdata_in = '0;
  logic        mem_ack_in = 1'b0;
  logic        stall_out;
  logic [4:0]  wb_rd_address;
  logic [31:0] wb_rd_data;
  logic        wb_we, ld_busy_out;
  logic [4:0]  ld_rd_out;

  mem_stage #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_address_in(rd_address_in), .rd_data_in(rd_data_in), .rd_we_in(rd_we_in),
    .inst_in(inst_in), .mem_address_in(mem_address_in),
    .mem_req_out(mem_req_out), .mem_wr_out(mem_wr_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in),
    .stall_out(stall_out), .wb_rd_address(wb_rd_address), .wb_rd_data(wb_rd_data),
    .wb_we(wb_we), .ld_busy_out(ld_busy_out), .ld_rd_out(ld_rd_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {logic [31:0] addr; logic wr; logic [7:0] wd;} xfer_t;
  typedef struct {logic [4:0] rd; logic [31:0] d;} wb_t;

  xfer_t xq[$];
  wb_t   wq[$];
  logic [7:0] mem [logic [31:0]];
  bit    ack_pat[$];
  bit    rdy_pat[$];
  int    ack_pct = 100;
  int    rdy_pct = 100;
  bit    sb_on = 1'b1;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic bit is_store(input logic [3:0] i);
    return i == I_SB || i == I_SH || i == I_SW;
  endfunction

  function automatic bit is_load(input logic [3:0] i);
    return i == I_LB || i == I_LH || i == I_LW || i == I_LBU || i == I_LHU;
  endfunction

  function automatic int nbytes(input logic [3:0] i);
    if (i == I_LB || i == I_LBU || i == I_SB) return 1;
    if (i == I_LH || i == I_LHU || i == I_SH) return 2;
    return 4;
  endfunction

  // Reference model: what the stage must do for one instruction, as queued expectations.
  task automatic model_push(input logic [3:0] ins, input logic [4:0] rd, input logic [31:0] d,
                            input logic we, input logic [31:0] a);
    xfer_t x;
    wb_t   w;
    logic [31:0] v;
    if (is_load(ins) || is_store(ins)) begin
      v = 0;
      for (int i = 0; i < nbytes(ins); i++) begin
        x.addr = a + 32'(i);
        x.wr   = is_store(ins);
        x.wd   = is_store(ins) ? d[8*i +: 8] : 8'h00;
        if (x.wr) mem[x.addr] = x.wd;
        else v = v + (32'(mrd(x.addr)) << (8 * i));
        xq.push_back(x);
      end
      if (is_load(ins) && rd != 0) begin
        if (ins == I_LB && v >= 128) v = v - 32'd256;
        if (ins == I_LH && v >= 32768) v = v - 32'd65536;
        w.rd = rd;
        w.d  = v;
        wq.push_back(w);
      end
    end else if (we && rd != 0) begin
      w.rd = rd;
      w.d  = d;
      wq.push_back(w);
    end
  endtask

  function automatic bit next_rdy();
    if (rdy_pat.size() > 0) return rdy_pat.pop_front();
    return $urandom_range(99) < rdy_pct;
  endfunction

  // Upstream driver: present one instruction and hold it until the stage accepts it.
  task automatic issue(input logic [3:0] ins, input logic [4:0] rd, input logic [31:0] d,
                       input logic we, input logic [31:0] a, output int stalls);
    bit done;
    model_push(ins, rd, d, we, a);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk_in);
      rdy_in = next_rdy();
      inst_in = ins; rd_address_in = rd; rd_data_in = d; rd_we_in = we; mem_address_in = a;
      #3;
      if (rdy_in && !stall_out) done = 1'b1;
      else if (rdy_in) stalls++;
    end
    chk(done, "issue_accepted", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    int s;
    for (int i = 0; i < n; i++) issue(I_NOP, 5'd0, 32'd0, 1'b0, 32'd0, s);
  endtask

  // Memory responder and transfer monitor.
  always @(negedge clk_in) begin
    bit a;
    xfer_t x;
    #1;
    a = (ack_pat.size() > 0) ? ack_pat.pop_front() : ($urandom_range(99) < ack_pct);
    mem_ack_in   = a;
    mem_rdata_in = 8'($urandom);
    if (rst_in && !rdy_in)
      chk(!mem_req_out && !stall_out, "frozen_req_stall", {mem_req_out, stall_out}, 64'd0);
    if (mem_req_out && a) begin
      if (!mem_wr_out) mem_rdata_in = mrd(mem_addr_out);
      if (sb_on) begin
        if (xq.size() == 0) begin
          chk(1'b0, "xfer_unexpected", {mem_wr_out, mem_wdata_out, mem_addr_out}, 64'd0);
        end else begin
          x = xq.pop_front();
          chk(mem_addr_out == x.addr && mem_wr_out == x.wr && (!x.wr || mem_wdata_out == x.wd),
              "xfer", {mem_wr_out, mem_wdata_out, mem_addr_out}, {x.wr, x.wd, x.addr});
        end
      end
    end
  end

  // Writeback monitor: one event per enabled edge with wb_we set.
  always @(posedge clk_in) begin
    bit e;
    wb_t w;
    e = rdy_in && rst_in;
    #1;
    if (sb_on && e && wb_we) begin
      if (wq.size() == 0) begin
        chk(1'b0, "wb_unexpected", {wb_rd_address, wb_rd_data}, 64'd0);
      end else begin
        w = wq.pop_front();
        chk(wb_rd_address == w.rd && wb_rd_data == w.d, "wb",
            {wb_rd_address, wb_rd_data}, {w.rd, w.d});
      end
    end
  end

  initial begin
    int s;
    logic [3:0] ins;
    logic [31:0] a;
    // Reset state, with a mem inst and rdy presented to show stall is held low.
    inst_in = I_LW; rdy_in = 1'b1;
    repeat (3) @(negedge clk_in);
    #3;
    chk(!mem_req_out && !wb_we && !stall_out && !ld_busy_out, "reset_ctrl",
        {mem_req_out, wb_we, stall_out, ld_busy_out}, 64'd0);
    chk(wb_rd_data == 0 && wb_rd_address == 0 && mem_addr_out == 0 && ld_rd_out == 0,
        "reset_data", {wb_rd_address, wb_rd_data}, 64'd0);
    inst_in = I_NOP;
    @(negedge clk_in);
    rst_in = 1'b1;

    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56; mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    mem[32'h20] = 8'h80; mem[32'h30] = 8'h80; mem[32'h31] = 8'hFF;

    issue(I_LW, 5'd3, 32'd0, 1'b0, 32'h1000, s);
    chk(s == 4, "lw_stall_cycles", 64'(s), 64'd4);
    issue(I_LB, 5'd4, 32'd0, 1'b0, 32'h20, s);
    issue(I_LBU, 5'd5, 32'd0, 1'b0, 32'h20, s);
    issue(I_LHU, 5'd6, 32'd0, 1'b0, 32'h30, s);
    issue(I_SH, 5'd7, 32'h0000BEEF, 1'b0, 32'h2001, s);
    // Ack gaps and rdy freeze in the middle of a word load.
    ack_pat = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    rdy_pat = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    issue(I_LW, 5'd8, 32'd0, 1'b0, 32'h1000, s);
    ack_pat.delete();
    rdy_pat.delete();
    issue(I_ADDI, 5'd5, 32'd7, 1'b1, 32'd0, s);
    chk(s == 0, "addi_no_stall", 64'(s), 64'd0);
    issue(I_ADDI, 5'd0, 32'd9, 1'b1, 32'd0, s);
    chk(s == 0, "addi_rd0_no_stall", 64'(s), 64'd0);
    idle(2);

    // Randomized traffic.
    rdy_pct = 80;
    ack_pct = 60;
    for (int n = 0; n < 200; n++) begin
      ins = 4'($urandom_range(9));
      a = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFFC + 32'($urandom_range(3)));
      issue(ins, ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom), $urandom, 1'($urandom), a, s);
    end
    rdy_pct = 100;
    idle(6);
    chk(xq.size() == 0, "xfer_queue_drained", 64'(xq.size()), 64'd0);
    chk(wq.size() == 0, "wb_queue_drained", 64'(wq.size()), 64'd0);

    // Wrapping halfword load aborted by reset during its second byte.
    sb_on   = 1'b0;
    ack_pct = 100;
    @(negedge clk_in);
    rdy_in = 1'b1; inst_in = I_LH; mem_address_in = 32'hFFFF_FFFF; rd_address_in = 5'd9;
    @(negedge clk_in);
    #3;
    chk(mem_req_out && mem_addr_out == 32'hFFFF_FFFF, "lh_first_addr",
        {mem_req_out, mem_addr_out}, {1'b1, 32'hFFFF_FFFF});
    @(negedge clk_in);
    #3;
    chk(mem_req_out && mem_addr_out == 32'h0, "lh_wrap_addr", {mem_req_out, mem_addr_out},
        {1'b1, 32'h0});
    chk(ld_busy_out && ld_rd_out == 5'd9, "ld_busy_rd", {ld_busy_out, ld_rd_out}, {1'b1, 5'd9});
    rst_in = 1'b0;
    #1;
    chk(!mem_req_out && !wb_we && !ld_busy_out && !stall_out, "reset_abort",
        {mem_req_out, wb_we, ld_busy_out, stall_out}, 64'd0);
    inst_in = I_NOP;
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #3;
    chk(!mem_req_out && !stall_out, "post_reset_idle", {mem_req_out, stall_out}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
